// File: rtl/ct_spsram_ctrl_pkg.sv
// ct_spsram_ctrl_pkg: shared constants, FSM states and write-mask helper for the SRAM controller
package ct_spsram_ctrl_pkg;
    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 2**ADDR_WIDTH;
    localparam int BYTES      = DATA_WIDTH/8;

    typedef enum logic [1:0] {RST, INIT, RUN} state_t;

    function automatic logic [DATA_WIDTH-1:0] be_to_wen(input logic [BYTES-1:0] be);
        logic [DATA_WIDTH-1:0] wen;
        for (int b = 0; b < BYTES; b++) wen[8*b +: 8] = {8{~be[b]}};
        return wen;
    endfunction
endpackage

// File: rtl/ct_spsram_4096x32_ctrl_if.sv
// ct_spsram_4096x32_ctrl_if: two requester ports plus the shared read-response channel
interface ct_spsram_4096x32_ctrl_if;
    import ct_spsram_ctrl_pkg::*;
    logic                  p0_vld, p0_rdy, p0_wr;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic [BYTES-1:0]      p0_be;
    logic                  p1_vld, p1_rdy, p1_wr;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic [BYTES-1:0]      p1_be;
    logic                  rvld, rid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output p0_vld, p0_wr, p0_addr, p0_wdata, p0_be,
        output p1_vld, p1_wr, p1_addr, p1_wdata, p1_be,
        input  p0_rdy, p1_rdy, rvld, rid, rdata
    );
    modport slave (
        input  p0_vld, p0_wr, p0_addr, p0_wdata, p0_be,
        input  p1_vld, p1_wr, p1_addr, p1_wdata, p1_be,
        output p0_rdy, p1_rdy, rvld, rid, rdata
    );
endinterface

// File: rtl/ct_spsram_rr_arb2.sv
// ct_spsram_rr_arb2: 2-input round-robin arbiter; ptr names the port preferred on a tie
module ct_spsram_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] vld,
    input  logic       accept,
    output logic [1:0] gnt,
    output logic       idx
);
    logic ptr;

    assign idx = vld[1] & (~vld[0] | ptr);
    assign gnt = {vld[1] & idx, vld[0] & ~idx};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= 1'b0;
        else if (accept) ptr <= ~idx;
endmodule

// File: rtl/ct_spsram_4096x32_ctrl.sv
// ct_spsram_4096x32_ctrl: zero-fills a 4096x32 SP-SRAM after reset, then arbitrates two requesters onto it
module ct_spsram_4096x32_ctrl
    import ct_spsram_ctrl_pkg::*;
(
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    init_start,
    output logic                    init_done,
    ct_spsram_4096x32_ctrl_if.slave bus,
    output logic [ADDR_WIDTH-1:0]   sram_a,
    output logic                    sram_cen,
    output logic                    sram_gwen,
    output logic [DATA_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0]   sram_d,
    input  logic [DATA_WIDTH-1:0]   sram_q
);
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, a_q, addr;
    logic [DATA_WIDTH-1:0] d_q, rdata_q, rdata, wdata;
    logic [BYTES-1:0]      be;
    logic [1:0]            vld, gnt;
    logic                  run, fill, accept, idx, wr, rd_acc, wr_acc, rvld_q, rid_q;

    assign run    = state == RUN;
    assign fill   = state == INIT;
    assign vld    = {bus.p1_vld, bus.p0_vld} & {2{run}};
    assign accept = |vld;

    ct_spsram_rr_arb2 u_arb (
        .clk    (forever_cpuclk),
        .rst_n  (cpurst_b),
        .vld    (vld),
        .accept (accept),
        .gnt    (gnt),
        .idx    (idx)
    );

    assign bus.p0_rdy = gnt[0];
    assign bus.p1_rdy = gnt[1];
    assign wr         = idx ? bus.p1_wr    : bus.p0_wr;
    assign addr       = idx ? bus.p1_addr  : bus.p0_addr;
    assign wdata      = idx ? bus.p1_wdata : bus.p0_wdata;
    assign be         = idx ? bus.p1_be    : bus.p0_be;
    // a write with no lanes enabled is accepted but never reaches the array
    assign rd_acc     = accept & ~wr;
    assign wr_acc     = accept & wr & |be;
    assign init_done  = run;
    assign rdata      = rvld_q ? sram_q : rdata_q;
    assign bus.rvld   = rvld_q;
    assign bus.rid    = rid_q;
    assign bus.rdata  = rdata;

    always_comb begin
        state_nxt = state == RST                                ? INIT :
                    fill && cnt == ADDR_WIDTH'(DEPTH - 1)       ? RUN  :
                    run && init_start && !rvld_q                ? INIT : state;
        sram_cen  = ~(fill | rd_acc | wr_acc);
        sram_gwen = ~(fill | wr_acc);
        sram_wen  = fill ? '0 : wr_acc ? be_to_wen(be) : '1;
        sram_a    = fill ? cnt : (rd_acc | wr_acc) ? addr : a_q;
        sram_d    = fill ? '0 : wr_acc ? wdata : d_q;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b)
        if (!cpurst_b) begin
            state   <= RST;
            cnt     <= '0;
            a_q     <= '0;
            d_q     <= '0;
            rvld_q  <= 1'b0;
            rid_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= fill ? cnt + 1'b1 : cnt;
            a_q     <= sram_a;
            d_q     <= sram_d;
            rvld_q  <= rd_acc;
            rid_q   <= rd_acc ? idx : rid_q;
            rdata_q <= rdata;
        end
endmodule

// File: tb/tb_ct_spsram_4096x32_ctrl.sv
// tb_ct_spsram_4096x32_ctrl: self-checking bench with an SRAM macro model and a word-level reference memory
module tb_ct_spsram_4096x32_ctrl;
    import ct_spsram_ctrl_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b1, init_start = 1'b0;
    logic        init_done, sram_cen, sram_gwen;
    logic [11:0] sram_a;
    logic [31:0] sram_wen, sram_d, sram_q;
    logic        vld[2], wr[2];
    logic [11:0] addr[2];
    logic [31:0] wdata[2];
    logic [3:0]  be[2];
    logic [31:0] mem[4096];
    logic [31:0] ref_mem[4096];
    int          n_cmp = 0, n_bad = 0, pref = 0;

    ct_spsram_4096x32_ctrl_if bus();
    assign bus.p0_vld = vld[0];   assign bus.p1_vld = vld[1];
    assign bus.p0_wr = wr[0];     assign bus.p1_wr = wr[1];
    assign bus.p0_addr = addr[0]; assign bus.p1_addr = addr[1];
    assign bus.p0_wdata = wdata[0]; assign bus.p1_wdata = wdata[1];
    assign bus.p0_be = be[0];     assign bus.p1_be = be[1];

    ct_spsram_4096x32_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .init_start     (init_start),
        .init_done      (init_done),
        .bus            (bus),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    always #5 clk = ~clk;

    // SRAM macro: bit-masked write, registered read
    always @(posedge clk)
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else sram_q <= mem[sram_a];
        end

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            vld[p] = 1'b0; wr[p] = 1'b0; addr[p] = '0; wdata[p] = '0; be[p] = '0;
        end
    endtask

    task automatic req(input int p, input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
        vld[p] = 1'b1; wr[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
    endtask

    function automatic int exp_win();
        if (vld[0] && vld[1]) return pref;
        if (vld[0]) return 0;
        if (vld[1]) return 1;
        return -1;
    endfunction

    function automatic logic [1:0] exp_rdy(input int w);
        return (w < 0) ? 2'b00 : (w == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic commit(input int w, output logic rd, output logic [31:0] q);
        rd = 1'b0; q = '0;
        if (w >= 0) begin
            pref = 1 - w;
            if (wr[w]) begin
                for (int b = 0; b < 4; b++)
                    if (be[w][b]) ref_mem[addr[w]][8*b +: 8] = wdata[w][8*b +: 8];
            end else begin
                rd = 1'b1; q = ref_mem[addr[w]];
            end
        end
    endtask

    task automatic run_cycle();
        logic rd; logic [31:0] q;
        @(negedge clk); commit(exp_win(), rd, q);
        @(posedge clk); #1 idle();
    endtask

    task automatic test_reset();
        int cyc, bad, miss;
        int hits[4096];
        rst_n = 1'b0; idle(); init_start = 1'b0; pref = 0; #1;
        n_cmp++; if ({bus.p0_rdy, bus.p1_rdy, bus.rvld, bus.rid, init_done} !== 5'b0) begin n_bad++; $display("FAIL rst_ctl got %b want 00000", {bus.p0_rdy, bus.p1_rdy, bus.rvld, bus.rid, init_done}); end
        n_cmp++; if ({sram_cen, sram_gwen} !== 2'b11) begin n_bad++; $display("FAIL rst_cen_gwen got %b want 11", {sram_cen, sram_gwen}); end
        n_cmp++; if (sram_wen !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_wen got %h want ffffffff", sram_wen); end
        n_cmp++; if (sram_a !== 12'h0) begin n_bad++; $display("FAIL rst_a got %h want 000", sram_a); end
        n_cmp++; if (sram_d !== 32'h0) begin n_bad++; $display("FAIL rst_d got %h want 0", sram_d); end
        n_cmp++; if (bus.rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", bus.rdata); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        foreach (hits[i]) hits[i] = 0;
        cyc = 1; bad = 0;
        while (cyc < 5000) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (init_done) break;
            if ({bus.p0_rdy, bus.p1_rdy, sram_cen, sram_gwen} !== 4'b0 || sram_wen !== 32'h0 ||
                sram_d !== 32'h0 || sram_a !== 12'(cyc - 2)) bad++;
            else hits[sram_a]++;
        end
        miss = 0;
        foreach (hits[i]) if (hits[i] != 1) miss++;
        n_cmp++; if (cyc != 4098) begin n_bad++; $display("FAIL init_cycles got %0d want 4098", cyc); end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL init_drive bad_cycles got %0d want 0", bad); end
        n_cmp++; if (miss != 0) begin n_bad++; $display("FAIL init_coverage addrs_not_once got %0d want 0", miss); end
        foreach (ref_mem[i]) ref_mem[i] = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic rd, rd2; logic [31:0] q, q2; int w;
        idle(); req(0, 1'b1, 12'h123, 32'hDEAD_BEEF, 4'b0101);
        @(negedge clk); w = exp_win();
        n_cmp++; if ({bus.p1_rdy, bus.p0_rdy} !== exp_rdy(w)) begin n_bad++; $display("FAIL wr_rdy got %b want %b", {bus.p1_rdy, bus.p0_rdy}, exp_rdy(w)); end
        n_cmp++; if (sram_wen !== 32'hFF00_FF00) begin n_bad++; $display("FAIL wr_wen got %h want ff00ff00", sram_wen); end
        n_cmp++; if ({sram_cen, sram_gwen} !== 2'b00) begin n_bad++; $display("FAIL wr_cen_gwen got %b want 00", {sram_cen, sram_gwen}); end
        n_cmp++; if (sram_a !== 12'h123 || sram_d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_a_d got %h/%h want 123/deadbeef", sram_a, sram_d); end
        commit(w, rd, q);
        @(posedge clk); #1 idle(); req(0, 1'b0, 12'h123, '0, '0);
        @(negedge clk); w = exp_win();
        n_cmp++; if ({bus.p1_rdy, bus.p0_rdy, sram_cen, sram_gwen} !== {exp_rdy(w), 2'b01}) begin n_bad++; $display("FAIL rd_drive got %b want %b01", {bus.p1_rdy, bus.p0_rdy, sram_cen, sram_gwen}, exp_rdy(w)); end
        commit(w, rd, q);
        @(posedge clk); #1 idle(); req(1, 1'b1, 12'h123, 32'h5555_5555, 4'hF);
        @(negedge clk);
        n_cmp++; if ({bus.rvld, bus.rid} !== 2'b10) begin n_bad++; $display("FAIL rd_resp rvld/rid got %b want 10", {bus.rvld, bus.rid}); end
        n_cmp++; if (bus.rdata !== q) begin n_bad++; $display("FAIL rd_data got %h want %h", bus.rdata, q); end
        commit(exp_win(), rd2, q2);
        @(posedge clk); #1 idle();
        @(negedge clk);
        n_cmp++; if (bus.rvld !== 1'b0 || bus.rdata !== q) begin n_bad++; $display("FAIL rd_hold rvld/rdata got %b/%h want 0/%h", bus.rvld, bus.rdata, q); end
        @(posedge clk); #1;
    endtask

    task automatic test_both_reads();
        logic rd, prd; logic [31:0] q, pq; int w, pw;
        req(0, 1'b1, 12'h010, $urandom, 4'hF); run_cycle();
        req(1, 1'b1, 12'h020, $urandom, 4'hF); run_cycle();
        req(0, 1'b0, 12'h010, '0, '0); req(1, 1'b0, 12'h020, '0, '0);
        prd = 1'b0; pq = '0; pw = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); w = exp_win();
            n_cmp++; if ({bus.p1_rdy, bus.p0_rdy} !== exp_rdy(w)) begin n_bad++; $display("FAIL b2b_rdy[%0d] got %b want %b", i, {bus.p1_rdy, bus.p0_rdy}, exp_rdy(w)); end
            n_cmp++; if (bus.rvld !== prd) begin n_bad++; $display("FAIL b2b_rvld[%0d] got %b want %b", i, bus.rvld, prd); end
            if (prd) begin
                n_cmp++; if (bus.rid !== 1'(pw) || bus.rdata !== pq) begin n_bad++; $display("FAIL b2b_resp[%0d] got %b/%h want %b/%h", i, bus.rid, bus.rdata, 1'(pw), pq); end
            end
            commit(w, rd, q); prd = rd; pq = q; pw = w;
            @(posedge clk); #1;
        end
        idle();
        @(negedge clk);
        n_cmp++; if (bus.rvld !== 1'b1 || bus.rid !== 1'(pw) || bus.rdata !== pq) begin n_bad++; $display("FAIL b2b_last got %b/%b/%h want 1/%b/%h", bus.rvld, bus.rid, bus.rdata, 1'(pw), pq); end
        @(posedge clk); #1;
    endtask

    task automatic test_be0();
        logic rd; logic [31:0] q; int w;
        req(1, 1'b1, 12'h050, 32'hA5A5_5A5A, 4'hF); run_cycle();
        req(1, 1'b1, 12'h050, 32'h1234_5678, 4'h0);
        @(negedge clk); w = exp_win();
        n_cmp++; if ({bus.p1_rdy, bus.p0_rdy} !== exp_rdy(w)) begin n_bad++; $display("FAIL be0_rdy got %b want %b", {bus.p1_rdy, bus.p0_rdy}, exp_rdy(w)); end
        n_cmp++; if (sram_cen !== 1'b1) begin n_bad++; $display("FAIL be0_cen got %b want 1", sram_cen); end
        commit(w, rd, q);
        @(posedge clk); #1 idle(); req(1, 1'b0, 12'h050, '0, '0);
        @(negedge clk); commit(exp_win(), rd, q);
        @(posedge clk); #1 idle();
        @(negedge clk);
        n_cmp++; if (bus.rvld !== 1'b1 || bus.rdata !== q) begin n_bad++; $display("FAIL be0_read got %b/%h want 1/%h", bus.rvld, bus.rdata, q); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic rd, prd, acc; logic [31:0] q, pq; int w, pw;
        prd = 1'b0; pq = '0; pw = 0;
        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < 2; p++) begin
                vld[p] = 1'($urandom_range(0, 1)); wr[p] = 1'($urandom_range(0, 1));
                addr[p] = 12'h100 + 12'($urandom_range(0, 7)); wdata[p] = $urandom; be[p] = 4'($urandom_range(0, 15));
            end
            @(negedge clk); w = exp_win();
            acc = (w < 0) ? 1'b0 : wr[w] ? (be[w] != 4'h0) : 1'b1;
            n_cmp++; if ({bus.p1_rdy, bus.p0_rdy} !== exp_rdy(w)) begin n_bad++; $display("FAIL rnd_rdy[%0d] got %b want %b", i, {bus.p1_rdy, bus.p0_rdy}, exp_rdy(w)); end
            n_cmp++; if (sram_cen !== ~acc) begin n_bad++; $display("FAIL rnd_cen[%0d] got %b want %b", i, sram_cen, ~acc); end
            if (acc) begin
                n_cmp++; if (sram_a !== addr[w]) begin n_bad++; $display("FAIL rnd_addr[%0d] got %h want %h", i, sram_a, addr[w]); end
            end
            n_cmp++; if (bus.rvld !== prd) begin n_bad++; $display("FAIL rnd_rvld[%0d] got %b want %b", i, bus.rvld, prd); end
            if (prd) begin
                n_cmp++; if (bus.rid !== 1'(pw) || bus.rdata !== pq) begin n_bad++; $display("FAIL rnd_resp[%0d] got %b/%h want %b/%h", i, bus.rid, bus.rdata, 1'(pw), pq); end
            end
            commit(w, rd, q); prd = rd; pq = q; pw = w;
            @(posedge clk); #1;
        end
        idle(); run_cycle();
    endtask

    task automatic test_init_start();
        logic rd; logic [31:0] q; int bad;
        req(0, 1'b1, 12'hFFF, 32'hFFFF_FFFF, 4'hF); run_cycle();
        req(0, 1'b0, 12'hFFF, '0, '0);
        @(negedge clk); commit(exp_win(), rd, q);
        @(posedge clk); #1 idle(); init_start = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.rvld !== 1'b1 || bus.rdata !== q) begin n_bad++; $display("FAIL is_pre_read got %b/%h want 1/%h", bus.rvld, bus.rdata, q); end
        @(posedge clk); #1 init_start = 1'b0;
        @(negedge clk);
        n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL is_ignored_when_rvld init_done got %b want 1", init_done); end
        @(posedge clk); #1 init_start = 1'b1;
        @(posedge clk); #1 init_start = 1'b0;
        @(negedge clk);
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL is_drop init_done got %b want 0", init_done); end
        bad = 0;
        for (int k = 0; k < 4096; k++) begin
            if (k > 0) @(negedge clk);
            if (init_done !== 1'b0 || {sram_cen, sram_gwen} !== 2'b00 || sram_wen !== 32'h0 ||
                sram_d !== 32'h0 || sram_a !== 12'(k)) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL is_fill bad_cycles got %0d want 0", bad); end
        @(negedge clk);
        n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL is_done got %b want 1", init_done); end
        foreach (ref_mem[i]) ref_mem[i] = '0;
        @(posedge clk); #1 req(1, 1'b0, 12'hFFF, '0, '0);
        @(negedge clk); commit(exp_win(), rd, q);
        @(posedge clk); #1 idle();
        @(negedge clk);
        n_cmp++; if (bus.rvld !== 1'b1 || bus.rdata !== q) begin n_bad++; $display("FAIL is_cleared got %b/%h want 1/%h", bus.rvld, bus.rdata, q); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_init();
        int k;
        idle(); init_start = 1'b1;
        @(posedge clk); #1 init_start = 1'b0;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (sram_a === 12'h800 && init_done === 1'b0) break;
        end
        n_cmp++; if (k >= 5000) begin n_bad++; $display("FAIL mid_reach got timeout want addr 800"); end
        rst_n = 1'b0; #1;
        n_cmp++; if ({sram_cen, sram_gwen, init_done, bus.rvld} !== 4'b1100 || sram_wen !== 32'hFFFF_FFFF || sram_a !== 12'h0) begin
            n_bad++; $display("FAIL mid_async got %b/%h/%h want 1100/ffffffff/000", {sram_cen, sram_gwen, init_done, bus.rvld}, sram_wen, sram_a);
        end
        test_reset();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_both_reads();
        test_be0();
        test_random();
        test_init_start();
        test_reset_mid_init();
        test_both_reads();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
